// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state
// encoding, owner encoding and the default memory latency.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  // Owner / grant encoding
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // Default fixed memory latency (issue to valid read data)
  localparam int MEM_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant decision for the memory port arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate grants on contention);
// without it the data side always wins a tie.
module arb_grant_sel
  import mem_arb_pkg::*;
(
  input  logic i_if_req,
  input  logic i_dm_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic i_last_grant,
`endif
  output logic o_grant_valid,
  output logic o_grant_own
);

  // Pick the winner among the active requests
  always_comb begin
    o_grant_valid = i_if_req | i_dm_req;
    o_grant_own   = OWN_DATA;
    if (i_if_req && i_dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      // Tie: hand the port to whoever did not get it last time
      o_grant_own = (i_last_grant == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
`else
      // Tie: the data side holds the older instruction, so it goes first
      o_grant_own = OWN_DATA;
`endif
    end else if (i_if_req) begin
      o_grant_own = OWN_FETCH;
    end else begin
      o_grant_own = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch
// and the data stage. One access is in flight at a time; the winner gets a
// registered read word and a one-cycle ready pulse.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on contention).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  dm_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_owner;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic                  r_if_ready;
  logic                  r_dm_ready;

  logic                  w_grant_valid;
  logic                  w_grant_own;
  logic                  w_grant;
  logic                  w_busy;
  logic                  w_last_cnt;
  logic                  w_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic                  r_last_grant;
`endif

  arb_grant_sel u_grant_sel (
    .i_if_req      (if_req),
    .i_dm_req      (dm_req),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_grant  (r_last_grant),
`endif
    .o_grant_valid (w_grant_valid),
    .o_grant_own   (w_grant_own)
  );

  // Decode grant / completion conditions from the current state and counter
  always_comb begin
    w_busy     = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
    w_grant    = (r_state == ST_IDLE) && w_grant_valid;
    w_last_cnt = (r_cnt == CNT_WIDTH'(MEM_LATENCY - 1));
    w_done     = w_busy && w_last_cnt;
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = (w_grant_own == OWN_DATA) ? ST_BUSY_D : ST_BUSY_I;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (w_last_cnt) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Issue registers, wait counter, read-data capture and ready pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_owner     <= OWN_DATA;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below
      r_mem_en   <= 1'b0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      if (w_grant) begin
        r_cnt    <= '0;
        r_owner  <= w_grant_own;
        r_mem_en <= 1'b1;
        if (w_grant_own == OWN_DATA) begin
          r_mem_addr  <= dm_addr;
          r_mem_we    <= dm_we;
          r_mem_wdata <= dm_wdata;
        end else begin
          r_mem_addr  <= if_addr;
          r_mem_we    <= 1'b0;
          r_mem_wdata <= r_mem_wdata;
        end
      end else if (w_done) begin
        r_cnt    <= '0;
        r_mem_we <= 1'b0;
        if (r_owner == OWN_DATA) begin
          r_dm_ready <= 1'b1;
          // A store returns no data, so keep the last load result
          if (!r_mem_we) begin
            r_dm_rdata <= mem_rdata;
          end else begin
            r_dm_rdata <= r_dm_rdata;
          end
        end else begin
          r_if_ready <= 1'b1;
          r_if_rdata <= mem_rdata;
        end
      end else if (w_busy) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the most recent winner for the next tie-break
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= OWN_FETCH;
    end else if (w_grant) begin
      r_last_grant <= w_grant_own;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;
  assign if_stall  = if_req & ~r_if_ready;
  assign dm_stall  = dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LATENCY=2).
// Honours ARB_ROUND_ROBIN_EN when selecting the expected tie-break order.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pipe = 32'h0BAD_0BAD;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .CNT_WIDTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Fixed memory contents
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0040_0000: rom = 32'h2008_0005;
      32'h0040_0004: rom = 32'h8C09_0004;
      32'h1001_0000: rom = 32'h1234_5678;
      32'h1001_0008: rom = 32'hCAFE_F00D;
      default:       rom = 32'hBAD0_BAD0;
    endcase
  endfunction

  // Memory model: read data valid only in the cycle after the issue cycle
  always @(posedge clock) begin
    if (mem_en) mem_pipe <= mem_we ? 32'hFFFF_FFFF : rom(mem_addr);
    else        mem_pipe <= 32'h0BAD_0BAD;
  end
  assign mem_rdata = mem_pipe;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0;
    dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    tick(2);
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if ({if_ready, dm_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b want 00", {if_ready, dm_ready}); end
    n_cmp++; if ({if_rdata, dm_rdata} !== 64'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, dm_rdata}); end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_fetch_only;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    #1;
    n_cmp++; if (if_stall !== 1'b1) begin n_bad++; $display("FAIL fo_stall0: got %b want 1", if_stall); end
    tick(1);
    n_cmp++; if ({mem_en, mem_we} !== 2'b10) begin n_bad++; $display("FAIL fo_issue: got en/we %b want 10", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 32'h0040_0000) begin n_bad++; $display("FAIL fo_addr: got %h want 00400000", mem_addr); end
    tick(1);
    n_cmp++; if ({mem_en, if_ready, if_stall} !== 3'b001) begin n_bad++; $display("FAIL fo_wait: got en/rdy/stall %b want 001", {mem_en, if_ready, if_stall}); end
    n_cmp++; if (mem_addr !== 32'h0040_0000) begin n_bad++; $display("FAIL fo_addr_hold: got %h want 00400000", mem_addr); end
    tick(1);
    n_cmp++; if ({if_ready, if_stall, dm_ready} !== 3'b100) begin n_bad++; $display("FAIL fo_ready: got rdy/stall/dmrdy %b want 100", {if_ready, if_stall, dm_ready}); end
    n_cmp++; if (if_rdata !== 32'h2008_0005) begin n_bad++; $display("FAIL fo_rdata: got %h want 20080005", if_rdata); end
    if_req = 1'b0;
    tick(1);
    n_cmp++; if ({if_ready, mem_en} !== 2'b00) begin n_bad++; $display("FAIL fo_after: got rdy/en %b want 00", {if_ready, mem_en}); end
  endtask

  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 32'h0040_0004;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000;
    tick(1);
    n_cmp++; if ({mem_en, mem_we} !== 2'b10) begin n_bad++; $display("FAIL sim_issue_d: got en/we %b want 10", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 32'h1001_0000) begin n_bad++; $display("FAIL sim_addr_d: got %h want 10010000", mem_addr); end
    n_cmp++; if ({if_stall, dm_stall} !== 2'b11) begin n_bad++; $display("FAIL sim_stalls: got %b want 11", {if_stall, dm_stall}); end
    tick(2);
    n_cmp++; if ({dm_ready, if_ready, if_stall} !== 3'b101) begin n_bad++; $display("FAIL sim_dm_ready: got dm/if/ifstall %b want 101", {dm_ready, if_ready, if_stall}); end
    n_cmp++; if (dm_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL sim_dm_rdata: got %h want 12345678", dm_rdata); end
    dm_req = 1'b0;
    tick(1);
    n_cmp++; if ({mem_en, dm_ready} !== 2'b10) begin n_bad++; $display("FAIL sim_issue_i: got en/dmrdy %b want 10", {mem_en, dm_ready}); end
    n_cmp++; if (mem_addr !== 32'h0040_0004) begin n_bad++; $display("FAIL sim_addr_i: got %h want 00400004", mem_addr); end
    tick(2);
    n_cmp++; if ({if_ready, dm_ready} !== 2'b10) begin n_bad++; $display("FAIL sim_if_ready: got if/dm %b want 10", {if_ready, dm_ready}); end
    n_cmp++; if (if_rdata !== 32'h8C09_0004) begin n_bad++; $display("FAIL sim_if_rdata: got %h want 8c090004", if_rdata); end
    if_req = 1'b0;
    tick(1);
  endtask

  task automatic test_store;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
    tick(1);
    n_cmp++; if ({mem_en, mem_we} !== 2'b11) begin n_bad++; $display("FAIL st_issue: got en/we %b want 11", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 32'h1001_0004) begin n_bad++; $display("FAIL st_addr: got %h want 10010004", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL st_wdata: got %h want deadbeef", mem_wdata); end
    tick(1);
    n_cmp++; if ({mem_en, dm_ready} !== 2'b00) begin n_bad++; $display("FAIL st_wait: got en/rdy %b want 00", {mem_en, dm_ready}); end
    n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL st_wdata_hold: got %h want deadbeef", mem_wdata); end
    tick(1);
    n_cmp++; if (dm_ready !== 1'b1) begin n_bad++; $display("FAIL st_ready: got %b want 1", dm_ready); end
    n_cmp++; if (dm_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL st_rdata_kept: got %h want 12345678", dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    tick(1);
  endtask

  task automatic test_back_to_back;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    tick(1);
    n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL b2b_en1: got %b want 1", mem_en); end
    tick(2);
    n_cmp++; if ({if_ready, mem_en} !== 2'b10) begin n_bad++; $display("FAIL b2b_ready1: got rdy/en %b want 10", {if_ready, mem_en}); end
    n_cmp++; if (if_rdata !== 32'h2008_0005) begin n_bad++; $display("FAIL b2b_rdata1: got %h want 20080005", if_rdata); end
    if_addr = 32'h0040_0004;
    tick(1);
    n_cmp++; if ({mem_en, if_ready} !== 2'b10) begin n_bad++; $display("FAIL b2b_en2: got en/rdy %b want 10", {mem_en, if_ready}); end
    n_cmp++; if (mem_addr !== 32'h0040_0004) begin n_bad++; $display("FAIL b2b_addr2: got %h want 00400004", mem_addr); end
    tick(2);
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready2: got %b want 1", if_ready); end
    n_cmp++; if (if_rdata !== 32'h8C09_0004) begin n_bad++; $display("FAIL b2b_rdata2: got %h want 8c090004", if_rdata); end
    if_req = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid_access;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0008;
    tick(1);
    n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL rm_issue: got %b want 1", mem_en); end
    tick(1);
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({mem_en, dm_ready} !== 2'b00) begin n_bad++; $display("FAIL rm_async: got en/rdy %b want 00", {mem_en, dm_ready}); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rm_addr: got %h want 0", mem_addr); end
    tick(1);
    n_cmp++; if ({dm_ready, dm_stall} !== 2'b01) begin n_bad++; $display("FAIL rm_no_ready: got rdy/stall %b want 01", {dm_ready, dm_stall}); end
    reset_n = 1'b1;
    tick(1);
    n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL rm_regrant: got %b want 1", mem_en); end
    n_cmp++; if (mem_addr !== 32'h1001_0008) begin n_bad++; $display("FAIL rm_addr2: got %h want 10010008", mem_addr); end
    tick(2);
    n_cmp++; if (dm_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %b want 1", dm_ready); end
    n_cmp++; if (dm_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rm_rdata: got %h want cafef00d", dm_rdata); end
    dm_req = 1'b0;
    tick(1);
  endtask

  task automatic test_contention;
    logic [3:0] exp_data;
    logic [31:0] exp_addr;
`ifdef ARB_ROUND_ROBIN_EN
    exp_data = 4'b0101;
`else
    exp_data = 4'b1111;
`endif
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000;
    for (int k = 0; k < 4; k++) begin
      exp_addr = exp_data[k] ? 32'h1001_0000 : 32'h0040_0000;
      tick(1);
      n_cmp++; if ({mem_en, mem_addr} !== {1'b1, exp_addr}) begin n_bad++; $display("FAIL ct_grant%0d: got en=%b addr=%h want en=1 addr=%h", k, mem_en, mem_addr, exp_addr); end
      tick(2);
      n_cmp++; if ({dm_ready, if_ready} !== {exp_data[k], ~exp_data[k]}) begin n_bad++; $display("FAIL ct_ready%0d: got dm/if %b%b want %b%b", k, dm_ready, if_ready, exp_data[k], ~exp_data[k]); end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset;
    test_fetch_only;
    test_simultaneous;
    test_store;
    test_back_to_back;
    test_reset_mid_access;
    test_contention;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
